aes_spi_responder: RTL and testbench

Serial-side responder for the AES SPI link. It is the target end of the single-clock, chip-select framed bit stream that the SPI master drives.

- Captures a 128-bit data block and an Nk×32-bit key, MSB-first, from SDI.
- Hands the block and key to an attached cipher or inverse-cipher core through a start/done handshake.
- Returns the 128-bit core result MSB-first on SDO after a fixed gap.

One instance sits in front of each AES core (encrypt and decrypt) behind its own CS line.

---
 rtl/aes_spi_responder_if.sv | 26 ++
 rtl/aes_spi_responder.sv | 130 +++++++++++++
 tb/tb_aes_spi_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_spi_responder_if.sv
// Serial link plus cipher-core handshake for one AES SPI responder.
// The slave modport is the responder; the master modport is the SPI master and core side.
interface aes_spi_responder_if #(
  parameter int unsigned Nk = 4
);
  logic             cs_n;
  logic             sdi;
  logic             sdo;
  logic [127:0]     core_data;
  logic [Nk*32-1:0] core_key;
  logic             core_start;
  logic [127:0]     core_out;
  logic             core_done;
  logic             frame_done;
  logic             overrun;

  modport slave (
    input  cs_n, sdi, core_out, core_done,
    output sdo, core_data, core_key, core_start, frame_done, overrun
  );

  modport master (
    output cs_n, sdi, core_out, core_done,
    input  sdo, core_data, core_key, core_start, frame_done, overrun
  );
endinterface

// File: rtl/aes_spi_responder.sv
// Target end of the AES SPI link: captures block and key, starts the core,
// then streams the core result MSB-first after a fixed gap.
module aes_spi_responder #(
  parameter int unsigned Nk  = 4,
  parameter int unsigned GAP = 4
) (
  input logic                clk,
  input logic                rst_n,
  aes_spi_responder_if.slave bus
);
  localparam int unsigned N    = 128 + Nk * 32;
  localparam int unsigned CntW = $clog2(N);
  localparam int unsigned GapW = $clog2(GAP + 1);

  localparam logic [CntW-1:0] LastPayload = CntW'(N - 1);
  localparam logic [CntW-1:0] LastResult  = CntW'(127);
  localparam logic [GapW-1:0] LastGap     = GapW'(GAP - 1);

  typedef enum logic [1:0] {StRecv, StWait, StSend, StDone} state_e;

  state_e           r_state;
  logic [CntW-1:0]  r_bit_cnt;
  logic [GapW-1:0]  r_gap_cnt;
  logic [N-2:0]     r_shift;
  logic [127:0]     r_result;
  logic             r_res_valid;
  logic             r_sdo;
  logic             r_start;
  logic             r_frame_done;
  logic             r_overrun;
  logic [127:0]     r_core_data;
  logic [Nk*32-1:0] r_core_key;

  logic [N-1:0]     w_payload;
  logic             w_capture;
  logic [127:0]     w_result;

  always_comb begin
    w_payload = {r_shift, bus.sdi};
    w_capture = bus.core_done && !r_res_valid;
    // A missing result is sent as zeros rather than whatever the register last held.
    w_result  = w_capture ? bus.core_out : (r_res_valid ? r_result : 128'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StRecv;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_shift      <= '0;
      r_result     <= '0;
      r_res_valid  <= 1'b0;
      r_sdo        <= 1'b0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_core_data  <= '0;
      r_core_key   <= '0;
    end else begin
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      if (bus.cs_n) begin
        r_state     <= StRecv;
        r_bit_cnt   <= '0;
        r_gap_cnt   <= '0;
        r_res_valid <= 1'b0;
        r_sdo       <= 1'b0;
      end else begin
        unique case (r_state)
          StRecv: begin
            r_shift <= w_payload[N-2:0];
            if (r_bit_cnt == LastPayload) begin
              r_core_data <= w_payload[N-1 -: 128];
              r_core_key  <= w_payload[Nk*32-1:0];
              r_start     <= 1'b1;
              r_gap_cnt   <= '0;
              r_bit_cnt   <= '0;
              r_state     <= StWait;
            end else begin
              r_bit_cnt <= r_bit_cnt + CntW'(1);
            end
          end
          StWait: begin
            if (w_capture) begin
              r_result    <= bus.core_out;
              r_res_valid <= 1'b1;
            end
            if (r_gap_cnt == LastGap) begin
              r_sdo     <= w_result[127];
              r_result  <= {w_result[126:0], 1'b0};
              r_bit_cnt <= '0;
              r_state   <= StSend;
              if (!w_capture && !r_res_valid) r_overrun <= 1'b1;
            end else begin
              r_gap_cnt <= r_gap_cnt + GapW'(1);
            end
          end
          StSend: begin
            if (r_bit_cnt == LastResult) begin
              r_sdo        <= 1'b0;
              r_frame_done <= 1'b1;
              r_bit_cnt    <= '0;
              r_state      <= StDone;
            end else begin
              r_sdo     <= r_result[127];
              r_result  <= {r_result[126:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + CntW'(1);
            end
          end
          StDone: begin
            // This edge already samples the first payload bit of the next frame.
            r_res_valid <= 1'b0;
            r_gap_cnt   <= '0;
            r_shift     <= w_payload[N-2:0];
            r_bit_cnt   <= CntW'(1);
            r_state     <= StRecv;
          end
          default: r_state <= StRecv;
        endcase
      end
    end
  end

  assign bus.sdo        = r_sdo;
  assign bus.core_start = r_start;
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;
  assign bus.core_data  = r_core_data;
  assign bus.core_key   = r_core_key;
endmodule

// File: tb/tb_aes_spi_responder.sv
// Bench for aes_spi_responder: Nk=4 and Nk=8 instances driven from a vector table plus
// hand-written abort and reset sequences, checked against a frame-level reference model.
module tb_aes_spi_responder;
  localparam int Gap0 = 4;
  localparam int Gap1 = 5;
  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_spi_responder_if #(.Nk(4)) if0 ();
  aes_spi_responder_if #(.Nk(8)) if1 ();

  aes_spi_responder #(.Nk(4), .GAP(Gap0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  aes_spi_responder #(.Nk(8), .GAP(Gap1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int errors = 0;
  int checks = 0;
  logic [1:0]   exp_ovr;
  logic [127:0] last_data [2];
  logic [255:0] last_key  [2];

  typedef struct {
    int           sel;
    logic [127:0] data;
    logic [255:0] key;
    int           done_at;
    logic [127:0] exp_res;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in core: the FIPS-197 vector, otherwise a fixed keyed mix.
  function automatic logic [127:0] model_core(input logic [127:0] d, input logic [255:0] k,
                                              input int nk);
    if (nk == 4 && d == FipsPt && k[127:0] == FipsKey) return FipsCt;
    return {d[63:0], d[127:64]} ^ k[127:0] ^ k[255:128] ^ 128'h5a5a_3c3c_0f0f_9696_a5a5_c3c3_f0f0_6969;
  endfunction

  function automatic int gap_of(input int sel);
    return (sel == 0) ? Gap0 : Gap1;
  endfunction

  function automatic int nk_of(input int sel);
    return (sel == 0) ? 4 : 8;
  endfunction

  // Result the master should see: core output only if done lands inside the gap window.
  function automatic logic [127:0] exp_of(input int sel, input logic [127:0] d,
                                          input logic [255:0] k, input int done_at);
    if (done_at >= 1 && done_at <= gap_of(sel)) return model_core(d, k, nk_of(sel));
    return 128'd0;
  endfunction

  function automatic logic [255:0] rand_key(input int sel);
    logic [255:0] k;
    k = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    if (sel == 0) k[255:128] = '0;
    return k;
  endfunction

  function automatic logic [127:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive(input int sel, input logic cs_n, input logic sdi, input logic done,
                       input logic [127:0] res);
    if (sel == 0) begin
      if0.cs_n = cs_n; if0.sdi = sdi; if0.core_done = done; if0.core_out = res;
      if1.cs_n = 1'b1; if1.sdi = 1'b0; if1.core_done = 1'b0;
    end else begin
      if1.cs_n = cs_n; if1.sdi = sdi; if1.core_done = done; if1.core_out = res;
      if0.cs_n = 1'b1; if0.sdi = 1'b0; if0.core_done = 1'b0;
    end
  endtask

  task automatic sample(input int sel, output logic sdo, output logic st, output logic fd,
                        output logic ovr, output logic [127:0] d, output logic [255:0] k);
    if (sel == 0) begin
      sdo = if0.sdo; st = if0.core_start; fd = if0.frame_done; ovr = if0.overrun;
      d = if0.core_data; k = {128'd0, if0.core_key};
    end else begin
      sdo = if1.sdo; st = if1.core_start; fd = if1.frame_done; ovr = if1.overrun;
      d = if1.core_data; k = if1.core_key;
    end
  endtask

  // One frame on instance sel. abort_at >= 0 raises CS instead of payload bit abort_at;
  // rst_at > 0 pulses reset right after sampling the cycle k = rst_at past edge E.
  task automatic run_frame(input int sel, input logic [127:0] data, input logic [255:0] key,
                           input int done_at, input logic [127:0] exp_res,
                           input int abort_at, input int rst_at);
    int nk, gap, n, idle_bad, start_extra, fd_bad;
    logic sdo, st, fd, ovr, b;
    logic [127:0] d, got, res_now;
    logic [255:0] k;
    nk = nk_of(sel); gap = gap_of(sel); n = 128 + nk * 32;
    idle_bad = 0; start_extra = 0; fd_bad = 0; got = '0;
    for (int j = 0; j < n; j++) begin
      if (j == abort_at) begin
        drive(sel, 1'b1, 1'b0, 1'b0, 128'd0);
        for (int c = 0; c < 4; c++) begin
          @(posedge clk); #1;
          sample(sel, sdo, st, fd, ovr, d, k);
          if (st || fd || sdo) idle_bad++;
        end
        check("abort_quiet", 256'(idle_bad), 256'd0);
        check("abort_keeps_data", {128'd0, d}, {128'd0, last_data[sel]});
        check("abort_keeps_key", k, last_key[sel]);
        return;
      end
      b = (j < 128) ? data[127-j] : key[nk*32-1-(j-128)];
      drive(sel, 1'b0, b, 1'b0, rand_data());
      @(posedge clk); #1;
      sample(sel, sdo, st, fd, ovr, d, k);
      if (j < n - 1 && (st || fd || sdo)) idle_bad++;
    end
    check("start_at_e1", {255'd0, st}, 256'd1);
    check("core_data", {128'd0, d}, {128'd0, data});
    check("core_key", k, key);
    last_data[sel] = data;
    last_key[sel]  = key;
    for (int kk = 1; kk <= gap + 128; kk++) begin
      res_now = (kk == done_at) ? model_core(data, key, nk) : rand_data();
      drive(sel, 1'b0, $urandom_range(0, 1) == 1, kk == done_at, res_now);
      @(posedge clk); #1;
      sample(sel, sdo, st, fd, ovr, d, k);
      if (st) start_extra++;
      if (kk >= gap && kk < gap + 128) got[127-(kk-gap)] = sdo;
      else if (sdo) idle_bad++;
      if (fd != (kk == gap + 128)) fd_bad++;
      if (kk == rst_at) begin
        rst_n = 1'b0;
        #1;
        sample(sel, sdo, st, fd, ovr, d, k);
        check("rst_sdo_fd", {254'd0, sdo, fd}, 256'd0);
        check("rst_core_data", {128'd0, d}, 256'd0);
        drive(sel, 1'b1, 1'b0, 1'b0, 128'd0);
        #2 rst_n = 1'b1;
        exp_ovr = 2'b00;
        last_data[0] = '0; last_data[1] = '0; last_key[0] = '0; last_key[1] = '0;
        fd_bad = 0;
        for (int c = 0; c < 140; c++) begin
          @(posedge clk); #1;
          sample(sel, sdo, st, fd, ovr, d, k);
          if (fd || st || sdo) fd_bad++;
        end
        check("rst_no_frame_done", 256'(fd_bad), 256'd0);
        check("rst_overrun", {255'd0, ovr}, 256'd0);
        return;
      end
    end
    if (!(done_at >= 1 && done_at <= gap)) exp_ovr[sel] = 1'b1;
    check("start_once", 256'(start_extra), 256'd0);
    check("sdo_stream", {128'd0, got}, {128'd0, exp_res});
    check("sdo_idle_zero", 256'(idle_bad), 256'd0);
    check("frame_done_slot", 256'(fd_bad), 256'd0);
    check("overrun", {255'd0, ovr}, {255'd0, exp_ovr[sel]});
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic sdo, st, fd, ovr;
    logic [127:0] d, dd;
    logic [255:0] k, kk;
    exp_ovr = 2'b00;
    last_data[0] = '0; last_data[1] = '0; last_key[0] = '0; last_key[1] = '0;
    if0.cs_n = 1'b1; if0.sdi = 1'b0; if0.core_done = 1'b0; if0.core_out = '0;
    if1.cs_n = 1'b1; if1.sdi = 1'b0; if1.core_done = 1'b0; if1.core_out = '0;
    rst_n = 1'b0;
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sample(s, sdo, st, fd, ovr, d, k);
      check("reset_outputs", {252'd0, sdo, st, fd, ovr}, 256'd0);
      check("reset_core_data", {128'd0, d}, 256'd0);
      check("reset_core_key", k, 256'd0);
    end

    // Vector table: FIPS, window edges, Nk=8 back-to-back, late core, then random.
    vecs[0] = '{0, FipsPt, {128'd0, FipsKey}, 3, 128'd0};
    vecs[1] = '{0, rand_data(), rand_key(0), Gap0, 128'd0};
    vecs[2] = '{0, rand_data(), rand_key(0), 1, 128'd0};
    vecs[3] = '{1, rand_data(), rand_key(1), 2, 128'd0};
    vecs[4] = '{1, rand_data(), rand_key(1), Gap1, 128'd0};
    vecs[5] = '{1, rand_data(), rand_key(1), 1, 128'd0};
    vecs[6] = '{0, rand_data(), rand_key(0), Gap0 + 3, 128'd0};
    vecs[7] = '{0, rand_data(), rand_key(0), 2, 128'd0};
    for (int i = 8; i < 12; i++) begin
      vecs[i].sel     = (i % 2 == 0) ? 1 : 0;
      vecs[i].data    = rand_data();
      vecs[i].key     = rand_key(vecs[i].sel);
      vecs[i].done_at = $urandom_range(1, gap_of(vecs[i].sel) + 2);
    end
    for (int i = 0; i < 12; i++)
      vecs[i].exp_res = exp_of(vecs[i].sel, vecs[i].data, vecs[i].key, vecs[i].done_at);

    for (int i = 0; i < 12; i++)
      run_frame(vecs[i].sel, vecs[i].data, vecs[i].key, vecs[i].done_at, vecs[i].exp_res,
                -1, -1);

    // CS abort after 50 payload bits, then a complete frame on the same instance.
    dd = rand_data(); kk = rand_key(0);
    run_frame(0, dd, kk, 2, 128'd0, 50, -1);
    dd = rand_data(); kk = rand_key(0);
    run_frame(0, dd, kk, 2, exp_of(0, dd, kk, 2), -1, -1);

    // Async reset while result bit 60 is on SDO, then a normal frame.
    run_frame(0, FipsPt, {128'd0, FipsKey}, 3, FipsCt, -1, Gap0 + 60);
    run_frame(0, FipsPt, {128'd0, FipsKey}, 3, FipsCt, -1, -1);
    dd = rand_data(); kk = rand_key(1);
    run_frame(1, dd, kk, 3, exp_of(1, dd, kk, 3), -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
